// File: rtl/axis_stats_monitor_pkg.sv
// Shared types and constants for the AXI-Stream statistics monitor.
package axis_stats_monitor_pkg;

  localparam int unsigned STATS_COUNT_W = 32;
  localparam int unsigned STATS_LEN_W   = 16;
  localparam int unsigned ERR_W         = 2;

  localparam int unsigned ERR_VALID_DROP   = 0;
  localparam int unsigned ERR_TLAST_CHANGE = 1;

  // Snapshot payload for one channel; narrower instances zero-extend into it.
  typedef struct packed {
    logic [STATS_COUNT_W-1:0] xfer_count;
    logic [STATS_COUNT_W-1:0] pkt_count;
    logic [STATS_COUNT_W-1:0] stall_count;
    logic [STATS_LEN_W-1:0]   last_len;
    logic [STATS_LEN_W-1:0]   max_len;
    logic [ERR_W-1:0]         err;
  } axis_ch_stats_t;

endpackage

// File: rtl/axis_stats_monitor_if.sv
// Observed stream handshake bundle plus the monitor's live event strobes.
interface axis_stats_monitor_if #(
  parameter int unsigned NUM_CH = 4
);
  logic [NUM_CH-1:0] i_tvalid;
  logic [NUM_CH-1:0] i_tready;
  logic [NUM_CH-1:0] i_tlast;
  logic [NUM_CH-1:0] xfer;
  logic [NUM_CH-1:0] sop;
  logic [NUM_CH-1:0] eop;

  modport master (output i_tvalid, i_tready, i_tlast, input xfer, sop, eop);
  modport slave  (input i_tvalid, i_tready, i_tlast, output xfer, sop, eop);
endinterface

// File: rtl/axis_stats_monitor_ch.sv
// One monitored stream: live saturating counters, snapshot capture and optional
// protocol checker (enabled by AXIS_STATS_MONITOR_PROTO_CHECK_EN).
module axis_stats_monitor_ch
  import axis_stats_monitor_pkg::*;
#(
  parameter int unsigned COUNT_W       = 32,
  parameter int unsigned LEN_W         = 16,
  parameter bit          CLEAR_ON_SNAP = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tvalid,
  input  logic           tready,
  input  logic           tlast,
  input  logic           snap,
  output logic           xfer,
  output logic           sop,
  output logic           eop,
  output axis_ch_stats_t stats
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0]   LEN_MAX = '1;

  logic               sop_reg;
  logic [LEN_W-1:0]   len_acc, len_acc_n, len_inc;
  logic [COUNT_W-1:0] xfer_count, xfer_count_n;
  logic [COUNT_W-1:0] pkt_count, pkt_count_n;
  logic [COUNT_W-1:0] stall_count, stall_count_n;
  logic [LEN_W-1:0]   last_len, last_len_n;
  logic [LEN_W-1:0]   max_len, max_len_n;
  logic [ERR_W-1:0]   err, err_n;
  axis_ch_stats_t     snap_d;

  assign xfer    = tvalid & tready;
  assign eop     = xfer & tlast;
  assign sop     = xfer & sop_reg;
  assign len_inc = (len_acc == LEN_MAX) ? len_acc : len_acc + LEN_W'(1);

  // Next-state of the live counters, including this cycle's events
  always_comb begin
    len_acc_n     = len_acc;
    xfer_count_n  = xfer_count;
    pkt_count_n   = pkt_count;
    stall_count_n = stall_count;
    last_len_n    = last_len;
    max_len_n     = max_len;
    if (xfer) begin
      len_acc_n = tlast ? '0 : len_inc;
      if (xfer_count != CNT_MAX) xfer_count_n = xfer_count + COUNT_W'(1);
    end
    if (tvalid && !tready && stall_count != CNT_MAX)
      stall_count_n = stall_count + COUNT_W'(1);
    if (eop) begin
      last_len_n = len_inc;
      if (len_inc > max_len) max_len_n = len_inc;
      if (pkt_count != CNT_MAX) pkt_count_n = pkt_count + COUNT_W'(1);
    end
  end

`ifdef AXIS_STATS_MONITOR_PROTO_CHECK_EN
  logic prev_stall, prev_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
      prev_tlast <= 1'b0;
    end else begin
      prev_stall <= tvalid & ~tready;
      prev_tlast <= tlast;
    end
  end

  // A stalled beat must stay valid and keep its tlast until accepted
  always_comb begin
    err_n = err;
    if (prev_stall && !tvalid) err_n[ERR_VALID_DROP] = 1'b1;
    if (prev_stall && tvalid && (tlast != prev_tlast)) err_n[ERR_TLAST_CHANGE] = 1'b1;
  end
`else
  assign err_n = '0;
`endif

  always_comb begin
    snap_d             = '0;
    snap_d.xfer_count  = STATS_COUNT_W'(xfer_count_n);
    snap_d.pkt_count   = STATS_COUNT_W'(pkt_count_n);
    snap_d.stall_count = STATS_COUNT_W'(stall_count_n);
    snap_d.last_len    = STATS_LEN_W'(last_len_n);
    snap_d.max_len     = STATS_LEN_W'(max_len_n);
    snap_d.err         = err_n;
  end

  // sop_reg and len_acc survive a snapshot so in-flight packets stay tracked
  always_ff @(posedge clk) begin
    if (rst) begin
      sop_reg     <= 1'b1;
      len_acc     <= '0;
      xfer_count  <= '0;
      pkt_count   <= '0;
      stall_count <= '0;
      last_len    <= '0;
      max_len     <= '0;
      err         <= '0;
      stats       <= '0;
    end else begin
      if (xfer) sop_reg <= tlast;
      len_acc <= len_acc_n;
      if (snap) stats <= snap_d;
      if (snap && CLEAR_ON_SNAP) begin
        xfer_count  <= '0;
        pkt_count   <= '0;
        stall_count <= '0;
        last_len    <= '0;
        max_len     <= '0;
        err         <= '0;
      end else begin
        xfer_count  <= xfer_count_n;
        pkt_count   <= pkt_count_n;
        stall_count <= stall_count_n;
        last_len    <= last_len_n;
        max_len     <= max_len_n;
        err         <= err_n;
      end
    end
  end

endmodule

// File: rtl/axis_stats_monitor.sv
// Multi-channel AXI-Stream statistics monitor with snapshot-and-select read port.
// Protocol checker is built only when AXIS_STATS_MONITOR_PROTO_CHECK_EN is defined.
module axis_stats_monitor
  import axis_stats_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned COUNT_W       = STATS_COUNT_W,
  parameter int unsigned LEN_W         = STATS_LEN_W,
  parameter bit          CLEAR_ON_SNAP = 1'b1,
  localparam int unsigned RD_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_stats_monitor_if.slave  mon,
  input  logic                 snap,
  input  logic [RD_W-1:0]      rd_ch,
  output logic [COUNT_W-1:0]   rd_xfer_count,
  output logic [COUNT_W-1:0]   rd_pkt_count,
  output logic [COUNT_W-1:0]   rd_stall_count,
  output logic [LEN_W-1:0]     rd_last_len,
  output logic [LEN_W-1:0]     rd_max_len,
  output logic [ERR_W-1:0]     rd_err
);

  logic [NUM_CH-1:0] xfer_v, sop_v, eop_v;
  axis_ch_stats_t    ch_stats [NUM_CH];
  axis_ch_stats_t    sel;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axis_stats_monitor_ch #(
      .COUNT_W       (COUNT_W),
      .LEN_W         (LEN_W),
      .CLEAR_ON_SNAP (CLEAR_ON_SNAP)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tvalid (mon.i_tvalid[g]),
      .tready (mon.i_tready[g]),
      .tlast  (mon.i_tlast[g]),
      .snap   (snap),
      .xfer   (xfer_v[g]),
      .sop    (sop_v[g]),
      .eop    (eop_v[g]),
      .stats  (ch_stats[g])
    );
  end

  assign mon.xfer = xfer_v;
  assign mon.sop  = sop_v;
  assign mon.eop  = eop_v;

  // Out-of-range selects fall through to zero
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(rd_ch) == i) sel = ch_stats[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_xfer_count  <= '0;
      rd_pkt_count   <= '0;
      rd_stall_count <= '0;
      rd_last_len    <= '0;
      rd_max_len     <= '0;
      rd_err         <= '0;
    end else begin
      rd_xfer_count  <= sel.xfer_count[COUNT_W-1:0];
      rd_pkt_count   <= sel.pkt_count[COUNT_W-1:0];
      rd_stall_count <= sel.stall_count[COUNT_W-1:0];
      rd_last_len    <= sel.last_len[LEN_W-1:0];
      rd_max_len     <= sel.max_len[LEN_W-1:0];
      rd_err         <= sel.err;
    end
  end

endmodule

// File: tb/tb_axis_stats_monitor.sv
// Self-checking bench for axis_stats_monitor: per-cycle model compare plus
// directed scenarios with hand-computed snapshot values.
module tb_axis_stats_monitor;
  import axis_stats_monitor_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 32;
  localparam int unsigned LW  = 16;
  localparam int unsigned SCW = 4;
  localparam int unsigned SLW = 3;

`ifdef AXIS_STATS_MONITOR_PROTO_CHECK_EN
  localparam logic [1:0] EXP_DROP = 2'b01;
  localparam logic [1:0] EXP_CHG  = 2'b10;
`else
  localparam logic [1:0] EXP_DROP = 2'b00;
  localparam logic [1:0] EXP_CHG  = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic snap = 1'b0;
  logic s_snap = 1'b0;
  logic [1:0] rd_ch = '0;
  logic s_rd_ch = 1'b0;

  logic [CW-1:0]  rd_xfer_count, rd_pkt_count, rd_stall_count;
  logic [LW-1:0]  rd_last_len, rd_max_len;
  logic [1:0]     rd_err;
  logic [SCW-1:0] s_rd_xfer_count, s_rd_pkt_count, s_rd_stall_count;
  logic [SLW-1:0] s_rd_last_len, s_rd_max_len;
  logic [1:0]     s_rd_err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  logic [15:0] sop_seen;
  int gb;

  always #5 clk = ~clk;

  axis_stats_monitor_if #(.NUM_CH(NCH)) m_if ();
  axis_stats_monitor_if #(.NUM_CH(1))   s_if ();

  axis_stats_monitor #(.NUM_CH(NCH), .COUNT_W(CW), .LEN_W(LW), .CLEAR_ON_SNAP(1'b1)) dut (
    .clk(clk), .rst(rst), .mon(m_if), .snap(snap), .rd_ch(rd_ch),
    .rd_xfer_count(rd_xfer_count), .rd_pkt_count(rd_pkt_count),
    .rd_stall_count(rd_stall_count), .rd_last_len(rd_last_len),
    .rd_max_len(rd_max_len), .rd_err(rd_err)
  );

  axis_stats_monitor #(.NUM_CH(1), .COUNT_W(SCW), .LEN_W(SLW), .CLEAR_ON_SNAP(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .mon(s_if), .snap(s_snap), .rd_ch(s_rd_ch),
    .rd_xfer_count(s_rd_xfer_count), .rd_pkt_count(s_rd_pkt_count),
    .rd_stall_count(s_rd_stall_count), .rd_last_len(s_rd_last_len),
    .rd_max_len(s_rd_max_len), .rd_err(s_rd_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: true (unbounded) totals, clipped to register width when reported
  longint m_xfer[NCH], m_pkt[NCH], m_stall[NCH], m_len[NCH], m_last[NCH], m_max[NCH];
  bit     m_inpkt[NCH], m_pstall[NCH], m_plast[NCH];
  logic [1:0] m_err[NCH];
  longint s_xfer[NCH], s_pkt[NCH], s_stall[NCH], s_last[NCH], s_max[NCH];
  logic [1:0] s_err[NCH];
  longint e_xfer, e_pkt, e_stall, e_last, e_max;
  logic [1:0] e_err;

  function automatic longint clip(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_xfer[c] = 0; m_pkt[c] = 0; m_stall[c] = 0; m_len[c] = 0;
        m_last[c] = 0; m_max[c] = 0; m_err[c] = '0;
        m_inpkt[c] = 0; m_pstall[c] = 0; m_plast[c] = 0;
        s_xfer[c] = 0; s_pkt[c] = 0; s_stall[c] = 0; s_last[c] = 0; s_max[c] = 0; s_err[c] = '0;
      end
      e_xfer = 0; e_pkt = 0; e_stall = 0; e_last = 0; e_max = 0; e_err = '0;
    end else begin
      e_xfer = s_xfer[rd_ch]; e_pkt = s_pkt[rd_ch]; e_stall = s_stall[rd_ch];
      e_last = s_last[rd_ch]; e_max = s_max[rd_ch]; e_err = s_err[rd_ch];
      for (int c = 0; c < NCH; c++) begin
        bit v, r, l;
        v = m_if.i_tvalid[c]; r = m_if.i_tready[c]; l = m_if.i_tlast[c];
        if (v && r) begin
          m_xfer[c]++;
          m_len[c]++;
          if (l) begin
            m_pkt[c]++;
            m_last[c] = m_len[c];
            if (m_len[c] > m_max[c]) m_max[c] = m_len[c];
            m_len[c] = 0;
            m_inpkt[c] = 0;
          end else m_inpkt[c] = 1;
        end
        if (v && !r) m_stall[c]++;
`ifdef AXIS_STATS_MONITOR_PROTO_CHECK_EN
        if (m_pstall[c] && !v) m_err[c][0] = 1'b1;
        if (m_pstall[c] && v && (l != m_plast[c])) m_err[c][1] = 1'b1;
`endif
        m_pstall[c] = v && !r;
        m_plast[c] = l;
        if (snap) begin
          s_xfer[c] = clip(m_xfer[c], CW); s_pkt[c] = clip(m_pkt[c], CW);
          s_stall[c] = clip(m_stall[c], CW); s_last[c] = clip(m_last[c], LW);
          s_max[c] = clip(m_max[c], LW); s_err[c] = m_err[c];
          m_xfer[c] = 0; m_pkt[c] = 0; m_stall[c] = 0; m_last[c] = 0; m_max[c] = 0; m_err[c] = '0;
        end
      end
    end
  end

  // Per-cycle compare of strobes and read port against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        bit v, r, l;
        v = m_if.i_tvalid[c]; r = m_if.i_tready[c]; l = m_if.i_tlast[c];
        check($sformatf("xfer[%0d]", c), 64'(m_if.xfer[c]), 64'(v && r));
        check($sformatf("sop[%0d]", c), 64'(m_if.sop[c]), 64'(v && r && !m_inpkt[c]));
        check($sformatf("eop[%0d]", c), 64'(m_if.eop[c]), 64'(v && r && l));
      end
      check("model rd_xfer", 64'(rd_xfer_count), 64'(e_xfer));
      check("model rd_pkt", 64'(rd_pkt_count), 64'(e_pkt));
      check("model rd_stall", 64'(rd_stall_count), 64'(e_stall));
      check("model rd_last", 64'(rd_last_len), 64'(e_last));
      check("model rd_max", 64'(rd_max_len), 64'(e_max));
      check("model rd_err", 64'(rd_err), 64'(e_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input bit v, input bit r, input bit l);
    m_if.i_tvalid = '0; m_if.i_tready = '0; m_if.i_tlast = '0;
    m_if.i_tvalid[ch] = v; m_if.i_tready[ch] = r; m_if.i_tlast[ch] = l;
  endtask

  task automatic idle();
    m_if.i_tvalid = '0; m_if.i_tready = '0; m_if.i_tlast = '0;
  endtask

  task automatic send_pkt(input int ch, input int len);
    for (int b = 0; b < len; b++) begin
      drive(ch, 1'b1, 1'b1, b == len - 1);
      #1;
      if (m_if.sop[ch] && gb < 16) sop_seen[gb] = 1'b1;
      gb++;
      tick();
    end
  endtask

  task automatic take_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic read_check(input int ch, input longint x, input longint p, input longint s,
                            input longint ll, input longint ml, input logic [1:0] e);
    rd_ch = 2'(ch);
    tick();
    check($sformatf("ch%0d xfer", ch), 64'(rd_xfer_count), 64'(x));
    check($sformatf("ch%0d pkt", ch), 64'(rd_pkt_count), 64'(p));
    check($sformatf("ch%0d stall", ch), 64'(rd_stall_count), 64'(s));
    check($sformatf("ch%0d last_len", ch), 64'(rd_last_len), 64'(ll));
    check($sformatf("ch%0d max_len", ch), 64'(rd_max_len), 64'(ml));
    check($sformatf("ch%0d err", ch), 64'(rd_err), 64'(e));
  endtask

  initial begin
    idle();
    s_if.i_tvalid = '0; s_if.i_tready = '0; s_if.i_tlast = '0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset rd_xfer", 64'(rd_xfer_count), 64'd0);
    check("reset rd_max", 64'(rd_max_len), 64'd0);

    // Ch0: packets of 4, 1, 7 beats back to back
    sop_seen = '0; gb = 0;
    send_pkt(0, 4); send_pkt(0, 1); send_pkt(0, 7);
    idle();
    take_snap();
    read_check(0, 12, 3, 0, 7, 7, 2'b00);
    check("sop beats", 64'(sop_seen), 64'h0031);

    // Ch2: five stalled cycles then a 2-beat packet
    drive(2, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    drive(2, 1'b1, 1'b1, 1'b0); tick();
    drive(2, 1'b1, 1'b1, 1'b1); tick();
    idle();
    take_snap();
    read_check(2, 2, 1, 5, 2, 2, 2'b00);
    read_check(0, 0, 0, 0, 0, 0, 2'b00);
    read_check(1, 0, 0, 0, 0, 0, 2'b00);
    read_check(3, 0, 0, 0, 0, 0, 2'b00);

    // Ch3: snapshot in the middle of a 5-beat packet, then after it
    drive(3, 1'b1, 1'b1, 1'b0); tick(); tick();
    idle();
    take_snap();
    read_check(3, 2, 0, 0, 0, 0, 2'b00);
    drive(3, 1'b1, 1'b1, 1'b0); tick(); tick();
    drive(3, 1'b1, 1'b1, 1'b1); tick();
    idle();
    take_snap();
    read_check(3, 3, 1, 0, 5, 5, 2'b00);

    // Ch0: snapshot coincident with end of packet, then an empty snapshot
    drive(0, 1'b1, 1'b1, 1'b0); tick(); tick();
    drive(0, 1'b1, 1'b1, 1'b1);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    idle();
    read_check(0, 3, 1, 0, 3, 3, 2'b00);
    take_snap();
    read_check(0, 0, 0, 0, 0, 0, 2'b00);

    // Ch1: valid dropped after a stalled cycle
    drive(1, 1'b1, 1'b0, 1'b0); tick();
    idle(); tick();
    take_snap();
    read_check(1, 0, 0, 1, 0, 0, EXP_DROP);

    // Ch3: tlast changes while stalled
    drive(3, 1'b1, 1'b0, 1'b0); tick();
    drive(3, 1'b1, 1'b0, 1'b1); tick();
    drive(3, 1'b1, 1'b1, 1'b1); tick();
    idle();
    take_snap();
    read_check(3, 1, 1, 2, 1, 1, EXP_CHG);

    // Reset in the middle of a ch0 packet
    drive(0, 1'b1, 1'b1, 1'b0); tick(); tick();
    idle();
    rst = 1'b1; tick(); rst = 1'b0;
    check("post-rst rd_xfer", 64'(rd_xfer_count), 64'd0);
    check("post-rst rd_err", 64'(rd_err), 64'd0);
    drive(0, 1'b1, 1'b1, 1'b1);
    #1;
    check("post-rst sop", 64'(m_if.sop[0]), 64'd1);
    tick();
    idle();
    read_check(3, 0, 0, 0, 0, 0, 2'b00);
    read_check(0, 0, 0, 0, 0, 0, 2'b00);

    // Narrow instance: one 20-beat packet saturates 4-bit counts / 3-bit lengths
    for (int b = 0; b < 20; b++) begin
      s_if.i_tvalid = 1'b1; s_if.i_tready = 1'b1; s_if.i_tlast = (b == 19);
      tick();
    end
    s_if.i_tvalid = '0; s_if.i_tready = '0; s_if.i_tlast = '0;
    s_snap = 1'b1; tick(); s_snap = 1'b0;
    tick();
    check("sat xfer", 64'(s_rd_xfer_count), 64'd15);
    check("sat pkt", 64'(s_rd_pkt_count), 64'd1);
    check("sat stall", 64'(s_rd_stall_count), 64'd0);
    check("sat last_len", 64'(s_rd_last_len), 64'd7);
    check("sat max_len", 64'(s_rd_max_len), 64'd7);

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
